redirect_ctrl: RTL and testbench

Initiator side of the pipeline flush path. Arbitrates control-transfer requests: jump decoded in ID, and bne-taken/jr resolved in EX. Produces IF_flush/ID_flush for the flush/discard logic, and holds a PC redirect to the fetch stage until fetch accepts it. Sits between the ID/EX control decode and the IF stage PC mux.

---
 rtl/redirect_ctrl_if.sv | 32 +++
 rtl/redirect_ctrl.sv | 103 ++++++++++
 tb/tb_redirect_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/redirect_ctrl_if.sv
// Request/redirect bundle between ID/EX control decode, redirect_ctrl and the IF PC mux.
// redirect_ctrl uses the master modport; the surrounding pipeline uses the slave modport.
interface redirect_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             jump;
  logic [PC_W-1:0]  jump_target;
  logic             bne_taken;
  logic [PC_W-1:0]  branch_target;
  logic             jr;
  logic [PC_W-1:0]  jr_target;
  logic             stall;
  logic             imem_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             IF_flush;
  logic             ID_flush;
  logic             busy;
  logic             wait_err;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  jump, jump_target, bne_taken, branch_target, jr, jr_target, stall, imem_ready,
    output redirect_valid, redirect_pc, IF_flush, ID_flush, busy, wait_err, flush_count
  );

  modport slave (
    output jump, jump_target, bne_taken, branch_target, jr, jr_target, stall, imem_ready,
    input  redirect_valid, redirect_pc, IF_flush, ID_flush, busy, wait_err, flush_count
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Control-transfer arbiter: raises IF/ID flushes and holds a PC redirect until fetch accepts it.
// Optional REDIRECT_STATS_EN builds a saturating count of discarded instruction slots.
module redirect_ctrl #(
  parameter int PC_W     = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  redirect_ctrl_if.master bus
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            wait_err_q;
  logic            ex_req;
  logic            id_req;
  logic [PC_W-1:0] sel_target;
  logic            if_flush_c;
  logic            id_flush_c;

  // EX requests are older than the ID jump, so jr > bne_taken > jump
  always_comb begin
    ex_req     = bus.bne_taken | bus.jr;
    id_req     = bus.jump & ~bus.stall;
    sel_target = bus.jump_target;
    if (bus.jr)
      sel_target = bus.jr_target;
    else if (bus.bne_taken)
      sel_target = bus.branch_target;
    if_flush_c = reset_n & ((state == REDIRECT) | ex_req | id_req);
    id_flush_c = reset_n & (state == IDLE) & ex_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wait_err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_req | id_req) begin
            state            <= REDIRECT;
            redirect_pc_q    <= sel_target;
            redirect_valid_q <= 1'b1;
            wait_cnt         <= 8'd0;
          end
        end
        REDIRECT: begin
          if (bus.imem_ready) begin
            state            <= IDLE;
            redirect_valid_q <= 1'b0;
          end else if (wait_cnt != MAX_WAIT_C) begin
            // saturating wait counter; the error stays sticky while we keep waiting
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == MAX_WAIT_C)
              wait_err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.IF_flush       = if_flush_c;
  assign bus.ID_flush       = id_flush_c;
  assign bus.busy           = (state != IDLE);
  assign bus.wait_err       = wait_err_q;

`ifdef REDIRECT_STATS_EN
  logic [CNT_W-1:0] flush_count_q;
  logic [CNT_W:0]   flush_sum;

  always_comb begin
    flush_sum = {1'b0, flush_count_q} + (CNT_W+1)'(if_flush_c) + (CNT_W+1)'(id_flush_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      flush_count_q <= '0;
    else if (flush_sum[CNT_W])
      flush_count_q <= '1;
    else
      flush_count_q <= flush_sum[CNT_W-1:0];
  end

  assign bus.flush_count = flush_count_q;
`else
  assign bus.flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: flushes checked in-line, redirect targets checked by a
// scoreboard monitor at each fetch acceptance.
module tb_redirect_ctrl;
  localparam int PC_W     = 32;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [PC_W-1:0] exp_q[$];

  redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  redirect_ctrl #(.PC_W(PC_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs just after the rising edge, then return at the falling edge
  task automatic applyStimulus(input logic j, input logic [31:0] jt, input logic b,
                               input logic [31:0] bt, input logic r, input logic [31:0] rt,
                               input logic s, input logic rdy);
    @(posedge clk);
    #1;
    bus.jump          = j;
    bus.jump_target   = jt;
    bus.bne_taken     = b;
    bus.branch_target = bt;
    bus.jr            = r;
    bus.jr_target     = rt;
    bus.stall         = s;
    bus.imem_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  // scoreboard monitor: every accepted redirect must match the oldest expected target
  always @(negedge clk) begin
    if (reset_n && bus.redirect_valid && bus.imem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected actual=0x%0h expected=none at %0t", bus.redirect_pc, $time);
      end else begin
        checkOutput("sb_redirect_pc", bus.redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.jump = 1'b1;
    bus.jump_target = 32'h40;
    bus.bne_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.jr = 1'b0;
    bus.jr_target = 32'h0;
    bus.stall = 1'b0;
    bus.imem_ready = 1'b0;
    #3;
    checkOutput("rst_IF_flush", 32'(bus.IF_flush), 32'h0);
    checkOutput("rst_ID_flush", 32'(bus.ID_flush), 32'h0);
    checkOutput("rst_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("rst_pc", bus.redirect_pc, 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_wait_err", 32'(bus.wait_err), 32'h0);
    checkOutput("rst_flush_count", 32'(bus.flush_count), 32'h0);
    bus.jump = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // plain jump accepted on the next cycle
    exp_q.push_back(32'h40);
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("j_IF_flush", 32'(bus.IF_flush), 32'h1);
    checkOutput("j_ID_flush", 32'(bus.ID_flush), 32'h0);
    checkOutput("j_busy0", 32'(bus.busy), 32'h0);
    idleCycle(1'b1);
    checkOutput("j_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("j_pc", bus.redirect_pc, 32'h40);
    checkOutput("j_redir_IF_flush", 32'(bus.IF_flush), 32'h1);
    checkOutput("j_busy1", 32'(bus.busy), 32'h1);
    idleCycle(1'b0);
    checkOutput("j_valid_done", 32'(bus.redirect_valid), 32'h0);
    checkOutput("j_busy_done", 32'(bus.busy), 32'h0);
    checkOutput("j_IF_clean", 32'(bus.IF_flush), 32'h0);

    // bne beats jump; a jr arriving during REDIRECT is ignored
    exp_q.push_back(32'h80);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bj_IF_flush", 32'(bus.IF_flush), 32'h1);
    checkOutput("bj_ID_flush", 32'(bus.ID_flush), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b1);
    checkOutput("bj_redir_ID_flush", 32'(bus.ID_flush), 32'h0);
    idleCycle(1'b0);
    checkOutput("bj_busy_done", 32'(bus.busy), 32'h0);
    checkOutput("bj_pc_hold", bus.redirect_pc, 32'h80);

    // jr beats bne
    exp_q.push_back(32'hC0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'hC0, 1'b0, 1'b0);
    checkOutput("jb_IF_flush", 32'(bus.IF_flush), 32'h1);
    checkOutput("jb_ID_flush", 32'(bus.ID_flush), 32'h1);
    idleCycle(1'b1);
    idleCycle(1'b0);

    // jump under stall is ignored until the stall drops
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("st_IF_flush", 32'(bus.IF_flush), 32'h0);
    checkOutput("st_ID_flush", 32'(bus.ID_flush), 32'h0);
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("st_busy", 32'(bus.busy), 32'h0);
    checkOutput("st_valid", 32'(bus.redirect_valid), 32'h0);
    exp_q.push_back(32'h44);
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("st_rel_IF_flush", 32'(bus.IF_flush), 32'h1);
    idleCycle(1'b1);
    checkOutput("st_rel_valid", 32'(bus.redirect_valid), 32'h1);
    idleCycle(1'b0);

    // fetch stalls past MAX_WAIT: sticky wait_err, redirect keeps waiting
    exp_q.push_back(32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= MAX_WAIT + 2; k++) begin
      idleCycle(1'b0);
      checkOutput("wt_valid", 32'(bus.redirect_valid), 32'h1);
      checkOutput("wt_IF_flush", 32'(bus.IF_flush), 32'h1);
      if (k == MAX_WAIT)
        checkOutput("wt_err_early", 32'(bus.wait_err), 32'h0);
      if (k == MAX_WAIT + 2)
        checkOutput("wt_err_set", 32'(bus.wait_err), 32'h1);
    end
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("wt_err_sticky", 32'(bus.wait_err), 32'h1);
    checkOutput("wt_busy_done", 32'(bus.busy), 32'h0);

    // asynchronous reset mid-REDIRECT drops the pending redirect
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    idleCycle(1'b0);
    checkOutput("ar_valid_pre", 32'(bus.redirect_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("ar_pc", bus.redirect_pc, 32'h0);
    checkOutput("ar_busy", 32'(bus.busy), 32'h0);
    checkOutput("ar_wait_err", 32'(bus.wait_err), 32'h0);
    checkOutput("ar_IF_flush", 32'(bus.IF_flush), 32'h0);
    checkOutput("ar_flush_count", 32'(bus.flush_count), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idleCycle(1'b0);
    checkOutput("ar_busy_after", 32'(bus.busy), 32'h0);

    // statistics: one bne redirect spending 3 cycles in REDIRECT
    exp_q.push_back(32'h400);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);
`ifdef REDIRECT_STATS_EN
    checkOutput("stats_flush_count", 32'(bus.flush_count), 32'd5);
`else
    checkOutput("stats_flush_count", 32'(bus.flush_count), 32'd0);
`endif

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
